// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension pipeline: Ctrl mode encodings
// and instruction-field bit positions within Imm26.
package imm_ext_pkg;

  localparam logic [2:0] CTRL_ADDI = 3'd0;
  localparam logic [2:0] CTRL_LDST = 3'd1;
  localparam logic [2:0] CTRL_CBZ  = 3'd2;
  localparam logic [2:0] CTRL_B    = 3'd3;
  localparam logic [2:0] CTRL_MOVZ = 3'd4;
  localparam logic [2:0] CTRL_MOVK = 3'd5;
  localparam logic [2:0] CTRL_MOVN = 3'd6;
  localparam logic [2:0] CTRL_RSVD = 3'd7;

  localparam int unsigned FIELD_W   = 26;

  localparam int unsigned ADDI_LSB  = 10;
  localparam int unsigned ADDI_MSB  = 21;
  localparam int unsigned ADDI_SH   = 22;
  localparam int unsigned LDST_LSB  = 12;
  localparam int unsigned LDST_MSB  = 20;
  localparam int unsigned CBZ_LSB   = 5;
  localparam int unsigned CBZ_MSB   = 23;
  localparam int unsigned MOV_LSB   = 5;
  localparam int unsigned MOV_MSB   = 20;
  localparam int unsigned HW_LSB    = 21;
  localparam int unsigned HW_MSB    = 22;

endpackage

// File: rtl/imm_field_decode.sv
// Combinational field extraction: picks the immediate field for each mode,
// pre-extends it to 26 bits, and reports the extension sign and shift amount.
module imm_field_decode
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned SCALE_BR = 0
) (
  input  logic [25:0] imm26_i,
  input  logic [2:0]  ctrl_i,
  output logic [25:0] field_o,
  output logic        sign_o,
  output logic [5:0]  shamt_o,
  output logic        err_o
);

  logic [1:0] hw;
  logic [5:0] br_shamt;

  assign hw       = imm26_i[HW_MSB:HW_LSB];
  assign br_shamt = (SCALE_BR != 0) ? 6'd2 : 6'd0;

  always_comb begin
    field_o = '0;
    sign_o  = 1'b0;
    shamt_o = '0;
    err_o   = 1'b0;
    case (ctrl_i)
      CTRL_ADDI: begin
        field_o = {14'b0, imm26_i[ADDI_MSB:ADDI_LSB]};
        shamt_o = imm26_i[ADDI_SH] ? 6'd12 : 6'd0;
      end
      CTRL_LDST: begin
        field_o = {{17{imm26_i[LDST_MSB]}}, imm26_i[LDST_MSB:LDST_LSB]};
        sign_o  = imm26_i[LDST_MSB];
      end
      CTRL_CBZ: begin
        field_o = {{7{imm26_i[CBZ_MSB]}}, imm26_i[CBZ_MSB:CBZ_LSB]};
        sign_o  = imm26_i[CBZ_MSB];
        shamt_o = br_shamt;
      end
      CTRL_B: begin
        field_o = imm26_i;
        sign_o  = imm26_i[FIELD_W-1];
        shamt_o = br_shamt;
      end
      CTRL_MOVZ, CTRL_MOVK, CTRL_MOVN: begin
        field_o = {10'b0, imm26_i[MOV_MSB:MOV_LSB]};
        shamt_o = {hw, 4'b0};
        // A halfword slot beyond the bus width is illegal on narrow builds.
        err_o   = (int'({hw, 4'b0}) >= int'(DATA_W));
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate extender: S1 holds the decoded field,
// S2 holds the shifted/merged result presented on BusImm.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned SCALE_BR = 0
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [25:0]       Imm26,
  input  logic [2:0]        Ctrl,
  input  logic [DATA_W-1:0] Rd_old,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] BusImm,
  output logic              out_err
);

  logic [25:0] dec_field;
  logic        dec_sign;
  logic [5:0]  dec_shamt;
  logic        dec_err;

  imm_field_decode #(
    .DATA_W   (DATA_W),
    .SCALE_BR (SCALE_BR)
  ) u_decode (
    .imm26_i (Imm26),
    .ctrl_i  (Ctrl),
    .field_o (dec_field),
    .sign_o  (dec_sign),
    .shamt_o (dec_shamt),
    .err_o   (dec_err)
  );

  logic              s1_valid_q, s1_valid_d;
  logic [25:0]       s1_field_q, s1_field_d;
  logic              s1_sign_q, s1_sign_d;
  logic [5:0]        s1_shamt_q, s1_shamt_d;
  logic [2:0]        s1_ctrl_q, s1_ctrl_d;
  logic              s1_err_q, s1_err_d;
  logic [DATA_W-1:0] s1_rd_q, s1_rd_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_imm_q, s2_imm_d;
  logic              s2_err_q, s2_err_d;

  logic              s2_adv;
  logic              accept;
  logic              s1_move;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] result;

  // Ready depends only on stage state and out_ready, never on in_valid.
  assign s2_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv;
  assign accept    = in_valid && in_ready && !flush;
  assign s1_move   = s1_valid_q && s2_adv && !flush;
  assign out_valid = s2_valid_q;
  assign BusImm    = s2_imm_q;
  assign out_err   = s2_err_q;

  always_comb begin
    ext     = {{(DATA_W-FIELD_W){s1_sign_q}}, s1_field_q};
    shifted = ext << s1_shamt_q;
    mask    = {{(DATA_W-16){1'b0}}, 16'hFFFF} << s1_shamt_q;
    case (s1_ctrl_q)
      CTRL_MOVK: result = (s1_rd_q & ~mask) | shifted;
      CTRL_MOVN: result = ~shifted;
      default:   result = shifted;
    endcase
    if (s1_err_q) begin
      result = '0;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_field_d = s1_field_q;
    s1_sign_d  = s1_sign_q;
    s1_shamt_d = s1_shamt_q;
    s1_ctrl_d  = s1_ctrl_q;
    s1_err_d   = s1_err_q;
    s1_rd_d    = s1_rd_q;
    s2_valid_d = s2_valid_q;
    s2_imm_d   = s2_imm_q;
    s2_err_d   = s2_err_q;

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_d = in_valid;
      end
      if (accept) begin
        s1_field_d = dec_field;
        s1_sign_d  = dec_sign;
        s1_shamt_d = dec_shamt;
        s1_ctrl_d  = Ctrl;
        s1_err_d   = dec_err;
        s1_rd_d    = Rd_old;
      end
      if (s2_adv) begin
        s2_valid_d = s1_valid_q;
      end
      if (s1_move) begin
        s2_imm_d = result;
        s2_err_d = s1_err_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_imm_q   <= s2_imm_d;
      s2_err_q   <= s2_err_d;
    end
  end

  // Payload registers are qualified by the valids and need no reset.
  always_ff @(posedge CLK) begin
    s1_field_q <= s1_field_d;
    s1_sign_q  <= s1_sign_d;
    s1_shamt_q <= s1_shamt_d;
    s1_ctrl_q  <= s1_ctrl_d;
    s1_err_q   <= s1_err_d;
    s1_rd_q    <= s1_rd_d;
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: a 64-bit scaled-branch instance and a
// 32-bit unscaled instance share the stimulus.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [25:0] imm26;
  logic [2:0]  ctrl;
  logic [63:0] rd_old;

  logic        in_ready64, out_valid64, err64;
  logic [63:0] busimm64;
  logic        in_ready32, out_valid32, err32;
  logic [31:0] busimm32;

  int n_checks = 0;
  int n_errors = 0;

  imm_extend_pipe #(
    .DATA_W   (64),
    .SCALE_BR (1)
  ) dut64 (
    .CLK       (clk),
    .Reset_n   (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready64),
    .Imm26     (imm26),
    .Ctrl      (ctrl),
    .Rd_old    (rd_old),
    .out_valid (out_valid64),
    .out_ready (out_ready),
    .BusImm    (busimm64),
    .out_err   (err64)
  );

  imm_extend_pipe #(
    .DATA_W   (32),
    .SCALE_BR (0)
  ) dut32 (
    .CLK       (clk),
    .Reset_n   (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .Imm26     (imm26),
    .Ctrl      (ctrl),
    .Rd_old    (rd_old[31:0]),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .BusImm    (busimm32),
    .out_err   (err32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, act, exp);
    end
  endtask

  // Single transaction with out_ready=1; result must appear two edges after accept.
  task automatic xfer(input string tag, input logic [2:0] c, input logic [25:0] imm,
                      input logic [63:0] rd, input logic [63:0] e64, input logic eerr64,
                      input logic [31:0] e32, input logic eerr32);
    @(negedge clk);
    check({tag, " ready"}, {63'b0, in_ready64}, 64'd1);
    in_valid  = 1'b1;
    ctrl      = c;
    imm26     = imm;
    rd_old    = rd;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    imm26    = '0;
    rd_old   = '0;
    @(negedge clk);
    check({tag, " lat1"}, {63'b0, out_valid64}, 64'd0);
    @(negedge clk);
    check({tag, " v64"}, {63'b0, out_valid64}, 64'd1);
    check({tag, " imm64"}, busimm64, e64);
    check({tag, " err64"}, {63'b0, err64}, {63'b0, eerr64});
    check({tag, " v32"}, {63'b0, out_valid32}, 64'd1);
    check({tag, " imm32"}, {32'b0, busimm32}, {32'b0, e32});
    check({tag, " err32"}, {63'b0, err32}, {63'b0, eerr32});
  endtask

  // Loads ADDI values 1 then 2 with out_ready=0 so both stages end up full.
  task automatic fill_both();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ctrl      = 3'd0;
    imm26     = 26'h400;
    @(posedge clk);
    #1;
    imm26 = 26'h800;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("fill valid", {63'b0, out_valid64}, 64'd1);
    check("fill ready", {63'b0, in_ready64}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    imm26     = '0;
    ctrl      = '0;
    rd_old    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst valid", {63'b0, out_valid64}, 64'd0);
    check("rst imm", busimm64, 64'd0);
    check("rst err", {63'b0, err64}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst ready", {63'b0, in_ready64}, 64'd1);

    xfer("movz hw2", 3'd4, 26'h57DDE0, 64'd0, 64'h0000_BEEF_0000_0000, 1'b0, 32'h0, 1'b1);
    xfer("movk hw1", 3'd5, 26'h3579A0, 64'h1111_2222_3333_4444,
         64'h1111_2222_ABCD_4444, 1'b0, 32'hABCD_4444, 1'b0);
    xfer("ldur neg", 3'd1, 26'h1FF000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
         32'hFFFF_FFFF, 1'b0);
    xfer("b neg", 3'd3, 26'h3FFFFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0,
         32'hFFFF_FFFF, 1'b0);
    xfer("rsvd", 3'd7, 26'h3FFFFFF, 64'hFFFF, 64'd0, 1'b1, 32'd0, 1'b1);
    xfer("addi sh", 3'd0, 26'h6AF000, 64'd0, 64'hABC000, 1'b0, 32'hABC000, 1'b0);
    xfer("addi", 3'd0, 26'h2AF000, 64'd0, 64'hABC, 1'b0, 32'hABC, 1'b0);
    xfer("cbz neg", 3'd2, 26'h800000, 64'd0, 64'hFFFF_FFFF_FFF0_0000, 1'b0,
         32'hFFFC_0000, 1'b0);
    xfer("cbz pos", 3'd2, 26'h2460, 64'd0, 64'h48C, 1'b0, 32'h123, 1'b0);
    xfer("movn hw3", 3'd6, 26'h624680, 64'd0, 64'hEDCB_FFFF_FFFF_FFFF, 1'b0, 32'd0, 1'b1);
    xfer("movn hw0", 3'd6, 26'h024680, 64'd0, 64'hFFFF_FFFF_FFFF_EDCB, 1'b0,
         32'hFFFF_EDCB, 1'b0);

    // Back-pressure: third input must wait while both stages are full.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ctrl      = 3'd0;
    imm26     = 26'h400;
    @(posedge clk);
    #1;
    imm26 = 26'h800;
    @(negedge clk);
    check("stall rdyB", {63'b0, in_ready64}, 64'd1);
    @(posedge clk);
    #1;
    imm26 = 26'hC00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall ready", {63'b0, in_ready64}, 64'd0);
      check("stall valid", {63'b0, out_valid64}, 64'd1);
      check("stall hold", busimm64, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("order B", busimm64, 64'd2);
    check("order Bv", {63'b0, out_valid64}, 64'd1);
    @(negedge clk);
    check("order C", busimm64, 64'd3);
    check("order Cv", {63'b0, out_valid64}, 64'd1);
    @(negedge clk);
    check("order drain", {63'b0, out_valid64}, 64'd0);

    // Flush with both stages full, plus a same-cycle input that must be dropped.
    fill_both();
    flush    = 1'b1;
    in_valid = 1'b1;
    imm26    = 26'hC00;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush valid", {63'b0, out_valid64}, 64'd0);
    check("flush ready", {63'b0, in_ready64}, 64'd1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush stale", {63'b0, out_valid64}, 64'd0);
    end

    // Reset with both stages full.
    fill_both();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst valid", {63'b0, out_valid64}, 64'd0);
    check("mrst ready", {63'b0, in_ready64}, 64'd1);
    check("mrst imm", busimm64, 64'd0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mrst stale", {63'b0, out_valid64}, 64'd0);
    end

    xfer("post rst", 3'd4, 26'h624680, 64'd0, 64'h1234_0000_0000_0000, 1'b0, 32'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter DATA_W, default 64, immediate bus width; legal values 32 or 64.
REQ-002 Parameter SCALE_BR, default 0, branch-offset scaling; 1 = left-shift CBZ/B offsets by 2.
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 Reset_n  in  1  reset, synchronous and active-low.
REQ-005 flush  in  1  synchronous pipeline clear.
REQ-006 in_valid  in  1  input transaction present.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 Imm26  in  26  instruction bits [25:0].
REQ-009 Ctrl  in  3  extension mode.
REQ-010 Rd_old  in  DATA_W  current destination value; used by MOVK only.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 BusImm  out  DATA_W  extended immediate.
REQ-014 out_err  out  1  illegal mode or shift for this DATA_W.

Function
REQ-015 Ctrl 0 (ADD/SUB) SHALL zero-extend Imm26[21:10], shifted left 12 when Imm26[22]=1.
REQ-016 Ctrl 1 (LDUR/STUR) SHALL sign-extend Imm26[20:12] from bit 20.
REQ-017 Ctrl 2 (CBZ) SHALL sign-extend Imm26[23:5]; shifted left 2 when SCALE_BR=1.
REQ-018 Ctrl 3 (B) SHALL sign-extend Imm26[25:0]; shifted left 2 when SCALE_BR=1.
REQ-019 Ctrl 4 (MOVZ) SHALL place Imm26[20:5] at bit 16*hw, hw=Imm26[22:21], all other bits 0.
REQ-020 Ctrl 5 (MOVK) SHALL replace Rd_old bits [16*hw+15:16*hw] with Imm26[20:5], other bits from Rd_old.
REQ-021 Ctrl 6 (MOVN) SHALL output the bitwise inverse of the Ctrl 4 result.
REQ-022 Ctrl 7, or Ctrl 4/5/6 with 16*hw >= DATA_W, SHALL give BusImm=0 and out_err=1; otherwise out_err=0.
REQ-023 Rd_old SHALL be sampled with Imm26 and Ctrl in the accept cycle.
REQ-024 Pipeline: two register stages; S1 latches the decoded field, sign/zero flag, shift amount and Rd_old; S2 holds the shifted/merged result.
REQ-025 Latency SHALL be 2 cycles from accept (in_valid & in_ready) to out_valid when out_ready=1.
REQ-026 With out_ready held 1, throughput SHALL be one result per cycle.
REQ-027 in_ready SHALL be 1 when S1 is empty or S1 advances this cycle; S1 advances when S2 is empty or (out_valid & out_ready).
REQ-028 While out_valid=1 and out_ready=0, BusImm and out_err SHALL hold stable.
REQ-029 Results SHALL leave in acceptance order; no drop, no duplicate.
REQ-030 flush=1 SHALL clear both stage valids next edge, ignore same-cycle input, and take priority over a simultaneous accept or hand-off.
REQ-031 in_ready SHALL not depend combinationally on in_valid.

Reset
REQ-032 Reset_n=0 at an edge SHALL clear S1/S2 valid, out_valid=0, BusImm=0, out_err=0.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.
REQ-034 Reset mid-transfer SHALL discard in-flight data; no result emerges after release.
REQ-035 Reset SHALL take priority over flush and handshakes.

Structure
REQ-036 Shared package imm_ext_pkg SHALL hold Ctrl mode constants (CTRL_ADDI..CTRL_RSVD) and field-position constants.
REQ-037 Field decode SHALL be one combinational sub-module imm_field_decode; pipeline and handshake logic live in imm_extend_pipe.

Verification
REQ-038 DATA_W=64, Ctrl=4, Imm26=0x57DDE0 (imm16=0xBEEF, hw=2) -> BusImm=0x0000_BEEF_0000_0000, out_err=0, 2 cycles after accept.
REQ-039 Ctrl=5, Imm26=0x3579A0 (0xABCD, hw=1), Rd_old=0x1111_2222_3333_4444 -> BusImm=0x1111_2222_ABCD_4444.
REQ-040 Ctrl=1, Imm26=0x1FF000 -> 0xFFFF_FFFF_FFFF_FFFF; Ctrl=3, SCALE_BR=1, Imm26=0x3FFFFFF -> 0xFFFF_FFFF_FFFF_FFFC.
REQ-041 DATA_W=32, Ctrl=4, hw=2 -> BusImm=0, out_err=1; Ctrl=7 any width -> out_err=1.
REQ-042 Three back-to-back inputs, out_ready=0 for 3 cycles: in_ready=0 once both stages are full, BusImm stable; on release all three emerge in order.
REQ-043 flush, then separately Reset_n=0, with both stages full -> out_valid=0 next cycle, in_ready=1, no stale result afterwards.
